// File: rtl/beagleg_pkg.sv
// beagleg_pkg: shared step-sequencer state encoding and FIFO record layout
package beagleg_pkg;
    typedef enum logic [2:0] {IDLE, POP0, LAT0, POP1, LAT1, PULSE, DELAY} seq_state_t;
    localparam int MASK_IDX = 0;
    localparam int DELAY_IDX = 1;
    localparam int FIFO_RECORD_WORDS = 2;
endpackage

// File: rtl/step_sequencer_if.sv
// step_sequencer_if: record FIFO read port between FIFO and step sequencer
interface step_sequencer_if #(parameter int WORD_SIZE = 8);
    logic                 fifo_empty;
    logic                 fifo_read_en;
    logic [WORD_SIZE-1:0] fifo_data;
    modport master (output fifo_read_en, input fifo_empty, input fifo_data);
    modport slave (input fifo_read_en, output fifo_empty, output fifo_data);
endinterface

// File: rtl/step_sequencer_tick_timer.sv
// tick_timer: prescaled, loadable, non-wrapping down-counter; done flags the last counted cycle
module tick_timer #(parameter int CW = 16) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] cnt_val,
    input  logic [CW-1:0] div_val,
    input  logic          count,
    output logic          done
);
    logic [CW-1:0] cnt, pre, div_q;
    assign done = count && cnt == CW'(1) && pre == '0;
    // load count and prescale, then step the count once per div_q cycles until it reaches zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            pre <= '0;
            div_q <= '0;
        end else if (load) begin
            cnt <= cnt_val;
            div_q <= div_val;
            pre <= div_val - CW'(1);
        end else if (count && cnt != '0) begin
            pre <= (pre == '0) ? div_q - CW'(1) : pre - CW'(1);
            cnt <= (pre == '0) ? cnt - CW'(1) : cnt;
        end
endmodule

// File: rtl/step_sequencer.sv
// step_sequencer: pops 2-word motion records and emits timed step pulses followed by a delay
module step_sequencer import beagleg_pkg::*; #(
    parameter int WORD_SIZE    = 8,
    parameter int PULSE_CYCLES = 16,
    parameter int TICK_DIV     = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    step_sequencer_if.master     fifo,
    output logic [WORD_SIZE-1:0] step_out,
    output logic                 busy,
    output logic                 underrun,
    input  logic                 underrun_clr
);
    localparam int DW = WORD_SIZE + $clog2(TICK_DIV);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int CW = (DW > PW) ? DW : PW;
    seq_state_t state, state_nxt;
    logic [WORD_SIZE-1:0] mask_q, delay_q;
    logic tmr_load, tmr_count, tmr_done, ret, set_und;
    logic [CW-1:0] tmr_cnt, tmr_div;
    assign fifo.fifo_read_en = state == POP0 || state == POP1;
    assign busy = state != IDLE;
    assign tmr_count = state == PULSE || state == DELAY;
    assign tmr_load = state == LAT1 || (state == PULSE && tmr_done && delay_q != '0);
    assign tmr_cnt = (state == LAT1) ? CW'(PULSE_CYCLES) : CW'(delay_q);
    assign tmr_div = (state == LAT1) ? CW'(1) : CW'(TICK_DIV);
    tick_timer #(.CW(CW)) u_timer (
        .clk(clk), .rst_n(rst_n), .load(tmr_load), .cnt_val(tmr_cnt),
        .div_val(tmr_div), .count(tmr_count), .done(tmr_done)
    );
    // next state; end of record falls through to the idle check so a waiting record pops without a gap
    always_comb begin
        state_nxt = state;
        ret = 1'b0;
        set_und = 1'b0;
        case (state)
            IDLE:  state_nxt = (enable && !fifo.fifo_empty) ? POP0 : IDLE;
            POP0:  state_nxt = LAT0;
            LAT0: begin
                state_nxt = fifo.fifo_empty ? IDLE : POP1;
                set_und = fifo.fifo_empty && enable;
            end
            POP1:  state_nxt = LAT1;
            LAT1:  state_nxt = PULSE;
            PULSE: begin
                state_nxt = (tmr_done && delay_q != '0) ? DELAY : PULSE;
                ret = tmr_done && delay_q == '0;
            end
            DELAY: ret = tmr_done;
            default: state_nxt = IDLE;
        endcase
        if (ret) begin
            state_nxt = (enable && !fifo.fifo_empty) ? POP0 : IDLE;
            set_und = enable && fifo.fifo_empty;
        end
    end
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    // capture the mask and delay words the cycle after each pop
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mask_q <= '0;
            delay_q <= '0;
        end else begin
            if (state == LAT0) mask_q <= fifo.fifo_data;
            if (state == LAT1) delay_q <= fifo.fifo_data;
        end
    // pins driven from a register so all of them switch on the same edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) step_out <= '0;
        else step_out <= (state_nxt == PULSE) ? mask_q : '0;
    // sticky underrun; a coincident set overrides the clear
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) underrun <= 1'b0;
        else underrun <= set_und ? 1'b1 : (underrun_clr ? 1'b0 : underrun);
endmodule
